// File: rtl/pkg_axi_lite.sv
// Shared AXI4-Lite definitions: response codes, bus widths and a byte-lane merge helper.
package pkg_axi_lite;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [AXI_DATA_WIDTH-1:0] merge_bytes(
    input logic [AXI_DATA_WIDTH-1:0]   old_word,
    input logic [AXI_DATA_WIDTH-1:0]   new_word,
    input logic [AXI_DATA_WIDTH/8-1:0] strb
  );
    logic [AXI_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < AXI_DATA_WIDTH / 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational register-window decode shared by the write and read address paths.
module axi_lite_addr_decode
  import pkg_axi_lite::*;
#(
  parameter int                ADDR_W    = AXI_ADDR_WIDTH,
  parameter int                NUM_REGS  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000,
  parameter int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              hit,
  output logic              aligned,
  output axi_resp_t         resp
);

  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(NUM_REGS * 4);

  logic [ADDR_W-1:0] offset;

  // Offset compare avoids overflow when the window sits at the top of the map.
  assign offset  = addr - BASE_ADDR;
  assign hit     = (addr >= BASE_ADDR) && (offset < SPAN);
  assign aligned = (addr[1:0] == 2'b00);
  assign idx     = offset[IDX_W+1:2];

  always_comb begin
    resp = OKAY;
    if (!hit)          resp = DECERR;
    else if (!aligned) resp = SLVERR;
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder exposing a bank of 32-bit control/status registers.
module axi_lite_slave_regs
  import pkg_axi_lite::*;
#(
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        NUM_REGS       = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_1000,
  parameter logic [NUM_REGS-1:0]       RO_MASK        = '0
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                         s_axi_awprot,
  input  logic                               s_axi_awvalid,
  output logic                               s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                               s_axi_wvalid,
  output logic                               s_axi_wready,
  output axi_resp_t                          s_axi_bresp,
  output logic                               s_axi_bvalid,
  input  logic                               s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                         s_axi_arprot,
  input  logic                               s_axi_arvalid,
  output logic                               s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]          s_axi_rdata,
  output axi_resp_t                          s_axi_rresp,
  output logic                               s_axi_rvalid,
  input  logic                               s_axi_rready,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                reg_wr_pulse,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] ro_in
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Handshakes: a transfer happens on the rising edge where valid && ready are both 1;
  // valid never waits on ready, and bvalid/rvalid with their payload hold until taken.
  logic                                   ready_en;
  logic                                   aw_held;
  logic                                   w_held;
  logic [AXI_ADDR_WIDTH-1:0]              aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0]              w_data_q;
  logic [STRB_W-1:0]                      w_strb_q;
  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] ro_words;

  logic      aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic      wr_hit, wr_aligned, rd_hit, rd_aligned;
  axi_resp_t wr_dec_resp, rd_dec_resp, wr_resp;
  logic      wr_ok, rd_ok;
  logic      unused_prot;

  assign ro_words = ro_in;
  assign reg_q    = regs;

  // ready_en keeps the readies low for one cycle after reset is released.
  assign s_axi_awready = ready_en && !areset && !aw_held;
  assign s_axi_wready  = ready_en && !areset && !w_held;
  assign s_axi_arready = ready_en && !areset && !s_axi_rvalid;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = aw_held && w_held && (!s_axi_bvalid || s_axi_bready);

  axi_lite_addr_decode #(
    .ADDR_W    (AXI_ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_wr_decode (
    .addr    (aw_addr_q),
    .idx     (wr_idx),
    .hit     (wr_hit),
    .aligned (wr_aligned),
    .resp    (wr_dec_resp)
  );

  axi_lite_addr_decode #(
    .ADDR_W    (AXI_ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_rd_decode (
    .addr    (s_axi_araddr),
    .idx     (rd_idx),
    .hit     (rd_hit),
    .aligned (rd_aligned),
    .resp    (rd_dec_resp)
  );

  assign wr_ok   = wr_hit && wr_aligned && !RO_MASK[wr_idx];
  assign wr_resp = (wr_dec_resp == OKAY && RO_MASK[wr_idx]) ? SLVERR : wr_dec_resp;
  assign rd_ok   = rd_hit && rd_aligned;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  always_ff @(posedge aclk) begin
    if (areset) begin
      ready_en     <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= OKAY;
    end else begin
      ready_en <= 1'b1;
      if (commit) begin
        aw_held <= 1'b0;
      end else if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (commit) begin
        w_held <= 1'b0;
      end else if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_resp;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      regs         <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit && wr_ok) begin
        regs[wr_idx]         <= merge_bytes(regs[wr_idx], w_data_q, w_strb_q);
        reg_wr_pulse[wr_idx] <= 1'b1;
      end
    end
  end

  // rdata samples regs before any same-edge commit, so a colliding read sees the old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= OKAY;
      s_axi_rdata  <= '0;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rresp  <= rd_dec_resp;
      if (!rd_ok)                s_axi_rdata <= '0;
      else if (RO_MASK[rd_idx])  s_axi_rdata <= ro_words[rd_idx];
      else                       s_axi_rdata <= regs[rd_idx];
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed plus randomized bench for axi_lite_slave_regs against an address-map reference model.
module tb_axi_lite_slave_regs;
  import pkg_axi_lite::*;

  localparam int          NR     = 8;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] RO_VAL = 32'h5555_AAAA;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic [31:0]      awaddr = '0;
  logic [2:0]       awprot = '0;
  logic             awvalid = 1'b0;
  logic             awready;
  logic [31:0]      wdata = '0;
  logic [3:0]       wstrb = '0;
  logic             wvalid = 1'b0;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready = 1'b0;
  logic [31:0]      araddr = '0;
  logic [2:0]       arprot = '0;
  logic             arvalid = 1'b0;
  logic             arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready = 1'b0;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0]    reg_wr_pulse;
  logic [NR*32-1:0] ro_in;

  int n_vec = 0;
  int n_err = 0;
  int b_hs_cnt = 0;

  logic [31:0] model_regs [NR];
  logic [31:0] exp_q [$];
  logic [1:0]  exp_resp_q [$];

  assign ro_in = {RO_VAL, {7{32'h0BAD_F00D}}};

  axi_lite_slave_regs #(
    .AXI_DATA_WIDTH (32),
    .AXI_ADDR_WIDTH (32),
    .NUM_REGS       (NR),
    .BASE_ADDR      (BASE),
    .RO_MASK        (8'h80)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .reg_q         (reg_q),
    .reg_wr_pulse  (reg_wr_pulse),
    .ro_in         (ro_in)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  always @(posedge aclk) if (bvalid && bready) b_hs_cnt++;

  // ---------------- reference model ----------------
  function automatic logic [1:0] model_resp(input logic [31:0] addr, input bit is_write);
    if (addr < BASE || addr >= BASE + 32'(4 * NR)) return DECERR;
    if (addr % 4 != 0) return SLVERR;
    if (is_write && (addr - BASE) / 4 == 7) return SLVERR;
    return OKAY;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int idx;
    if (model_resp(addr, 1'b0) != OKAY) return 32'h0;
    idx = int'((addr - BASE) / 4);
    return (idx == 7) ? RO_VAL : model_regs[idx];
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [NR-1:0] pulse);
    int idx;
    logic [31:0] mask;
    resp  = model_resp(addr, 1'b1);
    pulse = '0;
    if (resp == OKAY) begin
      idx  = int'((addr - BASE) / 4);
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      model_regs[idx] = (model_regs[idx] & ~mask) | (data & mask);
      pulse[idx] = 1'b1;
    end
  endtask

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = model_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
  endtask

  // ---------------- comparison ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic send_aw(input logic [31:0] addr, output bit ok);
    ok = 1'b0;
    awaddr = addr;
    awvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (awready) ok = 1'b1;
      @(negedge aclk);
    end
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, output bit ok);
    ok = 1'b0;
    wdata = data;
    wstrb = strb;
    wvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (wready) ok = 1'b1;
      @(negedge aclk);
    end
    wvalid = 1'b0;
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit ok_aw, ok_w;
    fork
      send_aw(addr, ok_aw);
      send_w(data, strb, ok_w);
    join
    check("aw_w_accept", {ok_aw, ok_w}, 2'b11);
  endtask

  task automatic recv_b(output logic [1:0] resp, output logic [NR-1:0] pulse, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    resp = '0;
    pulse = '0;
    bready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      if (bvalid) begin
        got = 1'b1;
        resp = bresp;
        pulse = reg_wr_pulse;
      end else begin
        lat++;
      end
      @(negedge aclk);
    end
    bready = 1'b0;
    check("b_arrive", got, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done, got, fire;
    ar_done = 1'b0;
    got = 1'b0;
    data = '0;
    resp = '0;
    araddr = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 50 && !ar_done; i++) begin
      fire = arready;
      @(negedge aclk);
      if (fire) ar_done = 1'b1;
    end
    arvalid = 1'b0;
    check("r_latency", rvalid, 1'b1);
    for (int i = 0; i < 50 && !got; i++) begin
      if (rvalid) begin
        got = 1'b1;
        data = rdata;
        resp = rresp;
        rready = 1'b1;
      end
      @(negedge aclk);
    end
    rready = 1'b0;
    check("r_arrive", got, 1'b1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic read_and_score(input string tag, input logic [31:0] addr);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    exp_q.push_back(model_read(addr));
    exp_resp_q.push_back(model_resp(addr, 1'b0));
    do_read(addr, d, r);
    ed = exp_q.pop_front();
    er = exp_resp_q.pop_front();
    check({tag, "_rdata"}, d, ed);
    check({tag, "_rresp"}, r, er);
  endtask

  task automatic write_and_score(input string tag, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
    logic [1:0]    r, er;
    logic [NR-1:0] p, ep;
    int            lat;
    model_write(addr, data, strb, er, ep);
    drive_write(addr, data, strb);
    recv_b(r, p, lat);
    check({tag, "_bresp"}, r, er);
    check({tag, "_pulse"}, p, ep);
    check({tag, "_b_lat"}, lat, 1);
    check({tag, "_reg_q"}, reg_q, model_flat());
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + 32'(4 * $urandom_range(0, NR - 1));
      3:       return BASE + 32'($urandom_range(0, 4 * NR - 1));
      4:       return ($urandom_range(0, 1) == 1) ? BASE - 32'd4 : BASE + 32'(4 * NR);
      default: return BASE + 32'h1C;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0]    r;
    logic [NR-1:0] p;
    logic [31:0]   old_val;
    int            lat, hs0;
    bit            ok;

    model_reset();
    repeat (3) @(negedge aclk);

    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    check("rst_reg_q", reg_q, '0);
    check("rst_pulse", reg_wr_pulse, '0);
    areset = 1'b0;
    check("rst_fall_readies", {awready, wready, arready}, 3'b000);
    @(negedge aclk);
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    write_and_score("wr_full", 32'h1000, 32'hDEAD_BEEF, 4'hF);
    read_and_score("rd_full", 32'h1000);

    // W leads AW by three cycles.
    send_w(32'hCAFE_BABE, 4'h3, ok);
    check("w_first_accept", ok, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("w_held_wready", wready, 1'b0);
      @(negedge aclk);
    end
    model_write(32'h1000, 32'hCAFE_BABE, 4'h3, r, p);
    send_aw(32'h1000, ok);
    check("aw_late_accept", ok, 1'b1);
    recv_b(r, p, lat);
    check("w_first_bresp", r, OKAY);
    check("w_first_pulse", p, 8'h01);
    check("w_first_wready", wready, 1'b1);
    read_and_score("rd_merge", 32'h1000);
    check("rd_merge_const", model_regs[0], 32'hDEAD_BABE);

    write_and_score("wr_decerr", 32'h2000, 32'h0123_4567, 4'hF);
    read_and_score("rd_misalign", 32'h1002);
    write_and_score("wr_ro", 32'h101C, 32'h1234_5678, 4'hF);
    read_and_score("rd_ro", 32'h101C);
    write_and_score("wr_strb0", 32'h1008, 32'hFFFF_FFFF, 4'h0);

    // B stalled while a second write is accepted behind it.
    bready = 1'b0;
    drive_write(32'h1008, 32'h1111_2222, 4'hF);
    model_write(32'h1008, 32'h1111_2222, 4'hF, r, p);
    @(negedge aclk);
    check("stall_b1_valid", bvalid, 1'b1);
    check("stall_b1_pulse", reg_wr_pulse, 8'h04);
    drive_write(32'h1004, 32'h3333_4444, 4'hF);
    for (int k = 0; k < 5; k++) begin
      check("stall_b1_stable", {bvalid, bresp}, {1'b1, OKAY});
      check("stall_no_commit", reg_q[32 +: 32], model_regs[1]);
      @(negedge aclk);
    end
    hs0 = b_hs_cnt;
    model_write(32'h1004, 32'h3333_4444, 4'hF, r, p);
    bready = 1'b1;
    @(negedge aclk);
    check("stall_b2_valid", bvalid, 1'b1);
    check("stall_b2_commit", reg_q, model_flat());
    check("stall_b2_pulse", reg_wr_pulse, p);
    @(negedge aclk);
    bready = 1'b0;
    check("stall_b_done", bvalid, 1'b0);
    @(negedge aclk);
    check("stall_hs_count", b_hs_cnt - hs0, 2);

    // Read and write commit to register 0 on the same edge.
    check("coll_idle", {awready, wready, arready}, 3'b111);
    old_val = model_regs[0];
    awaddr = 32'h1000; awvalid = 1'b1;
    wdata = 32'h7777_8888; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h1000; arvalid = 1'b1; bready = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    check("coll_rvalid", {rvalid, bvalid}, 2'b11);
    check("coll_old_data", rdata, old_val);
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0; bready = 1'b0;
    model_write(32'h1000, 32'h7777_8888, 4'hF, r, p);
    check("coll_reg_q", reg_q, model_flat());

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        write_and_score("rnd_wr", pick_addr(), $urandom, 4'($urandom_range(0, 15)));
      else
        read_and_score("rnd_rd", pick_addr());
    end

    // Reset with a pending B, a pending R and AR still asserted.
    drive_write(32'h1004, 32'h9999_AAAA, 4'hF);
    @(negedge aclk);
    araddr = 32'h1000; arvalid = 1'b1;
    @(negedge aclk);
    check("pre_rst_valids", {bvalid, rvalid}, 2'b11);
    areset = 1'b1;
    @(negedge aclk);
    check("mid_rst_ready_valid", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    check("mid_rst_reg_q", reg_q, '0);
    check("mid_rst_rdata", {rdata, reg_wr_pulse}, '0);
    arvalid = 1'b0;
    areset = 1'b0;
    check("mid_rst_fall_readies", {awready, wready, arready}, 3'b000);
    @(negedge aclk);
    check("mid_rst_back", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    model_reset();
    read_and_score("post_rst_rd", 32'h1004);
    write_and_score("post_rst_wr", 32'h1018, 32'hA5A5_5A5A, 4'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
